// File: rtl/aes_uart_pkg.sv
// aes_uart_pkg: command encodings, frame length and host FSM states shared by the AES UART blocks.
package aes_uart_pkg;
   localparam logic [1:0] CMD_K = 2'b00;
   localparam logic [1:0] CMD_E = 2'b01;
   localparam logic [1:0] CMD_D = 2'b10;
   localparam logic [7:0] CMD_BYTE_K = 8'h4B;
   localparam logic [7:0] CMD_BYTE_E = 8'h45;
   localparam logic [7:0] CMD_BYTE_D = 8'h44;
   localparam int FRAME_BYTES = 17;
   typedef enum logic [2:0] {S_IDLE, S_TX_BYTE, S_TX_GAP, S_RX_RSP, S_KEY_GUARD, S_DONE} state_t;
   function automatic logic [7:0] cmd_byte(input logic [1:0] cmd);
      return cmd == CMD_K ? CMD_BYTE_K : cmd == CMD_E ? CMD_BYTE_E : CMD_BYTE_D;
   endfunction
endpackage

// File: rtl/uart_rx.sv
// uart_rx: 8N1 deserializer sampling mid-bit; o_valid pulses one cycle per byte with a good stop bit.
module uart_rx #(
   parameter int CLKS_PER_BIT = 434
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       i_rx,
   output logic       o_valid,
   output logic [7:0] o_data
);
   localparam int CW = $clog2(CLKS_PER_BIT + 1);
   logic [1:0]    r_sync;
   logic          r_busy;
   logic          r_valid;
   logic [3:0]    r_bits;
   logic [CW-1:0] r_cnt;
   logic [7:0]    r_data;
   logic          w_rx;
   assign w_rx = r_sync[1];
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         r_sync  <= '1;
         r_busy  <= 1'b0;
         r_valid <= 1'b0;
         r_bits  <= 4'd0;
         r_cnt   <= '0;
         r_data  <= '0;
      end else begin
         r_sync  <= {r_sync[0], i_rx};
         r_valid <= 1'b0;
         if (!r_busy) begin
            if (!w_rx) begin
               r_busy <= 1'b1;
               r_bits <= 4'd0;
               r_cnt  <= '0;
            end
         end else if (r_cnt == CW'(r_bits == 4'd0 ? CLKS_PER_BIT / 2 : CLKS_PER_BIT - 1)) begin
            r_cnt  <= '0;
            r_bits <= r_bits + 4'd1;
            // a start bit that is high again at its midpoint was a glitch
            if (r_bits == 4'd0)
               r_busy <= !w_rx;
            else if (r_bits == 4'd9) begin
               r_busy  <= 1'b0;
               r_valid <= w_rx;
            end else
               r_data <= {w_rx, r_data[7:1]};
         end else
            r_cnt <= r_cnt + 1'b1;
      end
   assign o_valid = r_valid;
   assign o_data  = r_data;
endmodule

// File: rtl/uart_tx.sv
// uart_tx: 8N1 serializer; o_busy covers the whole frame including the stop bit.
module uart_tx #(
   parameter int CLKS_PER_BIT = 434
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       i_start,
   input  logic [7:0] i_data,
   output logic       o_tx,
   output logic       o_busy
);
   localparam int CW = $clog2(CLKS_PER_BIT + 1);
   logic [9:0]    r_sh;
   logic [3:0]    r_bits;
   logic [CW-1:0] r_cnt;
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         r_sh   <= '1;
         r_bits <= 4'd0;
         r_cnt  <= '0;
      end else if (r_bits == 4'd0) begin
         if (i_start) begin
            r_sh   <= {1'b1, i_data, 1'b0};
            r_bits <= 4'd10;
            r_cnt  <= '0;
         end
      end else if (r_cnt == CW'(CLKS_PER_BIT - 1)) begin
         r_cnt  <= '0;
         r_sh   <= {1'b1, r_sh[9:1]};
         r_bits <= r_bits - 4'd1;
      end else
         r_cnt <= r_cnt + 1'b1;
   // ones shift in behind the stop bit, so the line idles high by itself
   assign o_tx   = r_sh[0];
   assign o_busy = r_bits != 4'd0;
endmodule

// File: rtl/aes_uart_host.sv
// aes_uart_host: sends one command byte plus 16 payload bytes to the AES UART target
// and, for encrypt/decrypt, gathers the 16-byte reply.
module aes_uart_host
   import aes_uart_pkg::*;
#(
   parameter int CLK_FREQ       = 50_000_000,
   parameter int BAUD           = 115_200,
   parameter int KEY_GUARD_CLKS = 2048,
   parameter int TIMEOUT_CLKS   = 20 * (CLK_FREQ / BAUD) * 16
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         rx,
   output logic         tx,
   input  logic         req_valid,
   output logic         req_ready,
   input  logic [1:0]   req_cmd,
   input  logic [127:0] req_data,
   output logic         rsp_valid,
   output logic [127:0] rsp_data,
   output logic [4:0]   rsp_count,
   output logic         rsp_timeout,
   output logic         rsp_err,
   output logic         busy
);
   localparam int CLKS_PER_BIT = CLK_FREQ / BAUD;
   localparam int TW = $clog2(TIMEOUT_CLKS + 1);
   localparam int GW = $clog2(KEY_GUARD_CLKS + 1);
   state_t         r_state, w_next;
   logic [135:0]   r_buf;
   logic [4:0]     r_idx;
   logic           r_is_key;
   logic           r_gap;
   logic           r_timeout;
   logic           r_err;
   logic [TW-1:0]  r_tmo;
   logic [GW-1:0]  r_guard;
   logic [127:0]   r_rsp_data;
   logic [4:0]     r_rsp_count;
   logic           w_tx_start;
   logic           w_tx_busy;
   logic           w_rx_valid;
   logic [7:0]     w_rx_byte;
   uart_tx #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_tx (
      .clk(clk), .rst_n(rst_n), .i_start(w_tx_start), .i_data(r_buf[135:128]),
      .o_tx(tx), .o_busy(w_tx_busy)
   );
   uart_rx #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_rx (
      .clk(clk), .rst_n(rst_n), .i_rx(rx), .o_valid(w_rx_valid), .o_data(w_rx_byte)
   );
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) r_state <= S_IDLE;
      else        r_state <= w_next;
   always_comb begin
      w_next     = r_state;
      w_tx_start = 1'b0;
      case (r_state)
         S_IDLE:      if (req_valid) w_next = &req_cmd ? S_DONE : S_TX_BYTE;
         S_TX_BYTE:   if (!w_tx_busy) begin
            w_tx_start = 1'b1;
            w_next     = S_TX_GAP;
         end
         // r_gap holds off the busy check for the cycle in which uart_tx raises busy
         S_TX_GAP:    if (!r_gap && !w_tx_busy)
            w_next = r_idx < 5'(FRAME_BYTES) ? S_TX_BYTE : r_is_key ? S_KEY_GUARD : S_RX_RSP;
         S_RX_RSP:    w_next = (r_rsp_count == 5'd16 || (!w_rx_valid && r_tmo == '0)) ? S_DONE : S_RX_RSP;
         S_KEY_GUARD: if (r_guard == '0) w_next = S_DONE;
         default:     w_next = S_IDLE;
      endcase
   end
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         r_buf       <= '0;
         r_idx       <= 5'd0;
         r_is_key    <= 1'b0;
         r_gap       <= 1'b0;
         r_timeout   <= 1'b0;
         r_err       <= 1'b0;
         r_tmo       <= '0;
         r_guard     <= '0;
         r_rsp_data  <= '0;
         r_rsp_count <= 5'd0;
      end else begin
         r_gap <= w_tx_start;
         if (r_state == S_IDLE && req_valid) begin
            r_buf       <= {cmd_byte(req_cmd), req_data};
            r_is_key    <= req_cmd == CMD_K;
            r_idx       <= 5'd0;
            r_rsp_data  <= '0;
            r_rsp_count <= 5'd0;
            r_timeout   <= 1'b0;
            r_err       <= &req_cmd;
         end
         if (w_tx_start) begin
            r_buf <= {r_buf[127:0], 8'h00};
            r_idx <= r_idx + 5'd1;
         end
         // a byte arriving in the expiry cycle wins and reloads the counter
         if (r_state == S_TX_GAP && w_next == S_RX_RSP)
            r_tmo <= TW'(TIMEOUT_CLKS - 1);
         else if (r_state == S_RX_RSP)
            r_tmo <= w_rx_valid ? TW'(TIMEOUT_CLKS - 1) : r_tmo - 1'b1;
         if (r_state == S_TX_GAP && w_next == S_KEY_GUARD)
            r_guard <= GW'(KEY_GUARD_CLKS - 1);
         else if (r_state == S_KEY_GUARD)
            r_guard <= r_guard - 1'b1;
         if (r_state == S_RX_RSP && w_rx_valid && r_rsp_count != 5'd16) begin
            r_rsp_data  <= {r_rsp_data[119:0], w_rx_byte};
            r_rsp_count <= r_rsp_count + 5'd1;
         end
         if (r_state == S_RX_RSP && w_next == S_DONE && r_rsp_count != 5'd16)
            r_timeout <= 1'b1;
      end
   assign req_ready   = r_state == S_IDLE;
   assign busy        = r_state != S_IDLE;
   assign rsp_valid   = r_state == S_DONE;
   assign rsp_data    = r_rsp_data;
   assign rsp_count   = r_rsp_count;
   assign rsp_timeout = r_timeout;
   assign rsp_err     = r_err;
endmodule

// File: tb/tb_aes_uart_host.sv
// tb_aes_uart_host: drives requests, decodes the host's tx line, plays the target's replies
// and scores every rsp_valid against a queue of expected responses.
module tb_aes_uart_host;
   localparam int CPB = 4;
   localparam int KG  = 64;
   localparam int TMO = 20 * CPB * 16;
   typedef struct packed {
      logic [127:0] data;
      logic [4:0]   count;
      logic         tmo;
      logic         err;
   } rsp_t;
   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic         rx = 1'b1;
   logic         tx;
   logic         req_valid = 1'b0;
   logic         req_ready;
   logic [1:0]   req_cmd = 2'b00;
   logic [127:0] req_data = '0;
   logic         rsp_valid;
   logic [127:0] rsp_data;
   logic [4:0]   rsp_count;
   logic         rsp_timeout;
   logic         rsp_err;
   logic         busy;
   int           n_chk = 0;
   int           n_err = 0;
   int           n_rsp = 0;
   rsp_t         q[$];
   always #5 clk = ~clk;
   aes_uart_host #(
      .CLK_FREQ(1_000_000), .BAUD(250_000), .KEY_GUARD_CLKS(KG)
   ) dut (
      .clk(clk), .rst_n(rst_n), .rx(rx), .tx(tx),
      .req_valid(req_valid), .req_ready(req_ready), .req_cmd(req_cmd), .req_data(req_data),
      .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_count(rsp_count),
      .rsp_timeout(rsp_timeout), .rsp_err(rsp_err), .busy(busy)
   );
   task automatic chk(input string tag, input logic [135:0] got, input logic [135:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s got %h exp %h", tag, got, exp);
      end
   endtask
   always @(negedge clk)
      if (rst_n && rsp_valid) begin
         rsp_t e;
         n_rsp++;
         chk("rsp_pending", q.size() != 0, 1'b1);
         if (q.size() != 0) begin
            e = q.pop_front();
            chk("rsp_data", rsp_data, e.data);
            chk("rsp_count", rsp_count, e.count);
            chk("rsp_timeout", rsp_timeout, e.tmo);
            chk("rsp_err", rsp_err, e.err);
         end
      end
   task automatic get_byte(output logic [7:0] b, output logic ok);
      int k;
      k  = 0;
      b  = '0;
      ok = 1'b0;
      while (tx !== 1'b0 && k < 2000) begin
         @(negedge clk);
         k++;
      end
      if (tx !== 1'b0) return;
      repeat (CPB / 2) @(negedge clk);
      for (int i = 0; i < 8; i++) begin
         repeat (CPB) @(negedge clk);
         b[i] = tx;
      end
      repeat (CPB) @(negedge clk);
      ok = tx;
   endtask
   task automatic send_byte(input logic [7:0] b);
      logic [9:0] f;
      f = {1'b1, b, 1'b0};
      for (int i = 0; i < 10; i++) begin
         rx = f[i];
         repeat (CPB) @(negedge clk);
      end
   endtask
   task automatic wait_rsp(input int start, input int budget, output int lat);
      lat = 0;
      while (n_rsp == start && lat < budget) begin
         @(negedge clk);
         lat++;
      end
      chk("rsp_seen", n_rsp != start, 1'b1);
   endtask
   task automatic do_req(input logic [1:0] cmd, input logic [127:0] data,
                         input logic [127:0] rep, input int nrep, input logic stray);
      logic [135:0] line;
      logic [7:0]   b;
      logic [7:0]   cb;
      logic         ok;
      logic         all_ok;
      int           start;
      int           lat;
      rsp_t         e;
      cb      = cmd == 2'b00 ? 8'h4B : cmd == 2'b01 ? 8'h45 : 8'h44;
      e.data  = rep >> (8 * (16 - nrep));
      e.count = 5'(nrep);
      e.tmo   = cmd != 2'b00 && nrep < 16;
      e.err   = 1'b0;
      line    = '0;
      all_ok  = 1'b1;
      start   = n_rsp;
      @(negedge clk);
      req_cmd   = cmd;
      req_data  = data;
      req_valid = 1'b1;
      q.push_back(e);
      @(negedge clk);
      req_valid = 1'b0;
      chk("busy_ready", {busy, req_ready}, 2'b10);
      fork
         for (int i = 0; i < 17 && all_ok; i++) begin
            get_byte(b, ok);
            all_ok = all_ok & ok;
            line   = {line[127:0], b};
         end
         if (stray) begin
            repeat (60) @(negedge clk);
            send_byte(8'hA5);
         end
      join
      chk("frame_ok", all_ok, 1'b1);
      chk("cmd_byte", line[135:128], cb);
      chk("line", line, {cb, data});
      if (cmd == 2'b00) begin
         lat = 0;
         while (n_rsp == start && lat < 500) begin
            @(negedge clk);
            lat++;
            if (lat == 10) begin
               chk("guard_busy", {busy, req_ready, tx}, 3'b101);
               req_cmd   = 2'b01;
               req_valid = 1'b1;
            end
            if (lat == 11) req_valid = 1'b0;
         end
         chk("rsp_seen", n_rsp != start, 1'b1);
         chk("key_lat", lat >= KG && lat <= KG + 8, 1'b1);
      end else begin
         repeat (6) @(negedge clk);
         for (int j = 0; j < nrep; j++) send_byte(rep[127 - 8 * j -: 8]);
         wait_rsp(start, TMO + 500, lat);
         if (nrep < 16) chk("tmo_lat", lat >= TMO - 10 && lat <= TMO + 15, 1'b1);
         else           chk("rsp_lat", lat <= 8, 1'b1);
      end
      @(negedge clk);
      chk("ready_after", req_ready, 1'b1);
   endtask
   initial begin
      #1_000_000;
      $display("FAIL watchdog n_chk %0d", n_chk);
      $fatal(1, "watchdog");
   end
   initial begin
      rsp_t e;
      int   start;
      int   k;
      logic txlow;
      logic [7:0] b;
      logic ok;
      repeat (3) @(negedge clk);
      chk("rst_out", {tx, req_ready, busy, rsp_valid, rsp_timeout, rsp_err, rsp_count, rsp_data},
          {1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 128'd0});
      rst_n = 1'b1;
      repeat (3) @(negedge clk);
      chk("idle_ready", {req_ready, busy, tx}, 3'b101);
      do_req(2'b00, 128'h000102030405060708090a0b0c0d0e0f, '0, 0, 1'b0);
      do_req(2'b01, 128'h00112233445566778899aabbccddeeff,
             128'h69c4e0d86a7b0430d8cdb78070b4c55a, 16, 1'b0);
      repeat (20) @(negedge clk);
      chk("rsp_hold", rsp_data, 128'h69c4e0d86a7b0430d8cdb78070b4c55a);
      do_req(2'b10, 128'h69c4e0d86a7b0430d8cdb78070b4c55a,
             128'h00112233445566778899aabbccddeeff, 16, 1'b1);
      do_req(2'b01, 128'h00112233445566778899aabbccddeeff,
             {40'h1122334455, 88'h0}, 5, 1'b0);
      // illegal command: nothing on the line, quick error completion
      e.data  = '0;
      e.count = 5'd0;
      e.tmo   = 1'b0;
      e.err   = 1'b1;
      txlow   = 1'b0;
      @(negedge clk);
      start     = n_rsp;
      req_cmd   = 2'b11;
      req_data  = 128'hdeadbeef;
      req_valid = 1'b1;
      q.push_back(e);
      for (int i = 0; i < 3 && n_rsp == start; i++) begin
         @(negedge clk);
         req_valid = 1'b0;
         if (tx !== 1'b1) txlow = 1'b1;
      end
      req_valid = 1'b0;
      chk("err_lat", n_rsp != start, 1'b1);
      chk("err_tx_idle", txlow, 1'b0);
      repeat (5) @(negedge clk);
      // reset during the 8th byte on the line
      req_cmd   = 2'b01;
      req_data  = 128'h0123456789abcdef0123456789abcdef;
      req_valid = 1'b1;
      @(negedge clk);
      req_valid = 1'b0;
      for (int i = 0; i < 7; i++) get_byte(b, ok);
      k = 0;
      while (tx !== 1'b0 && k < 100) begin
         @(negedge clk);
         k++;
      end
      chk("byte8_start", tx, 1'b0);
      repeat (10) @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      chk("async_rst", {tx, req_ready, busy, rsp_valid, rsp_timeout, rsp_err, rsp_count, rsp_data},
          {1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 128'd0});
      q.delete();
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      repeat (60) @(negedge clk);
      chk("post_rst_idle", {req_ready, tx}, 2'b11);
      do_req(2'b01, 128'h00112233445566778899aabbccddeeff,
             128'h69c4e0d86a7b0430d8cdb78070b4c55a, 16, 1'b0);
      repeat (10) @(negedge clk);
      chk("q_empty", q.size(), 0);
      $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
      $finish;
   end
endmodule
